// File: rtl/wide_to_narrow.sv
// wide_to_narrow: serialises wide lines of IN_DATA_ELS narrow elements into
// a narrow beat stream. The highest-indexed element goes out first. On the
// final line of a packet, trailing elements with all-zero keep are skipped,
// and last is flagged on the lowest element that carries data.
module wide_to_narrow #(
   parameter int OUT_DATA_W  = -1,
   parameter int OUT_KEEP_W  = OUT_DATA_W / 8,
   parameter int IN_DATA_ELS = -1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   src_w_to_n_val,
   input  logic [IN_DATA_ELS-1:0][OUT_DATA_W-1:0] src_w_to_n_data,
   input  logic [IN_DATA_ELS-1:0][OUT_KEEP_W-1:0] src_w_to_n_keep,
   input  logic                                   src_w_to_n_last,
   output logic                                   w_to_n_src_rdy,
   output logic                                   w_to_n_dst_val,
   output logic [OUT_DATA_W-1:0]                  w_to_n_dst_data,
   output logic [OUT_KEEP_W-1:0]                  w_to_n_dst_keep,
   output logic                                   w_to_n_dst_last,
   input  logic                                   dst_w_to_n_rdy
);

   // Guard the index width against the unset default so it stays elaborable.
   localparam int ELS   = (IN_DATA_ELS < 2) ? 2 : IN_DATA_ELS;
   localparam int IDX_W = $clog2(ELS);
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ELS - 1);

   typedef enum logic [1:0] {
      ST_READY = 2'd0,
      ST_EMIT  = 2'd1
   } state_t;

   state_t                                state;
   logic                                  vld_p0;
   logic [IDX_W-1:0]                      idx_reg;
   logic [IDX_W-1:0]                      end_idx;
   logic [IN_DATA_ELS-1:0][OUT_DATA_W-1:0] line_data;
   logic [IN_DATA_ELS-1:0][OUT_KEEP_W-1:0] line_keep;
   logic                                  line_last;

   logic src_rdy_c;
   logic at_end;
   logic src_hs;
   logic dst_hs;

   // Index of the element that closes the line. A non-final line always runs
   // down to element 0; a final line stops at its lowest element with any
   // keep bit set, or emits only the top element when nothing is kept.
   function automatic logic [IDX_W-1:0] calc_end_idx(
      input logic [IN_DATA_ELS-1:0][OUT_KEEP_W-1:0] keep,
      input logic                                   last
   );
      logic [IDX_W-1:0] res;
      res = '0;
      if (last) begin
         res = TOP_IDX;
         for (int i = IN_DATA_ELS - 1; i >= 0; i--) begin
            if (|keep[i]) begin
               res = IDX_W'(i);
            end
         end
      end
      return res;
   endfunction

   assign at_end = (idx_reg == end_idx);
   assign src_hs = src_w_to_n_val & src_rdy_c;
   assign dst_hs = vld_p0 & dst_w_to_n_rdy;

   // Source ready: open in READY, and in EMIT only while the closing beat of
   // the current line is being taken, so the next line loads without a bubble.
   always_comb begin
      src_rdy_c = 1'b0;
      case (state)
         ST_READY: src_rdy_c = 1'b1;
         ST_EMIT:  src_rdy_c = dst_w_to_n_rdy & at_end;
         default:  src_rdy_c = 1'bx;
      endcase
      if (rst) begin
         src_rdy_c = 1'b0;
      end
   end

   // Control FSM: state, beat valid, down-counter and line keep/last.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_READY;
         vld_p0    <= 1'b0;
         idx_reg   <= TOP_IDX;
         line_keep <= '0;
         line_last <= 1'b0;
      end else begin
         case (state)
            ST_READY: begin
               if (src_hs) begin
                  state     <= ST_EMIT;
                  vld_p0    <= 1'b1;
                  idx_reg   <= TOP_IDX;
                  line_keep <= src_w_to_n_keep;
                  line_last <= src_w_to_n_last;
               end
            end
            ST_EMIT: begin
               if (src_hs) begin
                  idx_reg   <= TOP_IDX;
                  line_keep <= src_w_to_n_keep;
                  line_last <= src_w_to_n_last;
               end else if (dst_hs) begin
                  if (at_end) begin
                     state  <= ST_READY;
                     vld_p0 <= 1'b0;
                  end else begin
                     idx_reg <= idx_reg - 1'b1;
                  end
               end
            end
            default: begin
               state  <= ST_READY;
               vld_p0 <= 1'b0;
            end
         endcase
      end
   end

   // Line payload and its closing index, captured only on source handshake.
   always_ff @(posedge clk) begin
      if (src_hs) begin
         line_data <= src_w_to_n_data;
         end_idx   <= calc_end_idx(src_w_to_n_keep, src_w_to_n_last);
      end
   end

   assign w_to_n_src_rdy  = src_rdy_c;
   assign w_to_n_dst_val  = vld_p0 & ~rst;
   assign w_to_n_dst_data = line_data[idx_reg];
   assign w_to_n_dst_keep = line_keep[idx_reg];
   assign w_to_n_dst_last = vld_p0 & ~rst & line_last & at_end;

endmodule

// File: tb/tb_wide_to_narrow.sv
// Bench for wide_to_narrow: a beat-queue model built from the element order
// and trailing-keep rule is compared against the DUT on every cycle.
module tb_wide_to_narrow;

   localparam int DW  = 32;
   localparam int KW  = 4;
   localparam int ELS = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic                    clk;
   logic                    rst;
   logic                    src_val;
   logic [ELS-1:0][DW-1:0]  src_data;
   logic [ELS-1:0][KW-1:0]  src_keep;
   logic                    src_last;
   logic                    src_rdy;
   logic                    dst_val;
   logic [DW-1:0]           dst_data;
   logic [KW-1:0]           dst_keep;
   logic                    dst_last;
   logic                    dst_rdy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   bit rand_rdy = 0;

   beat_t exp_q[$];
   beat_t log_q[$];
   int    log_cyc[$];

   wide_to_narrow #(
      .OUT_DATA_W (DW),
      .OUT_KEEP_W (KW),
      .IN_DATA_ELS(ELS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .src_w_to_n_val (src_val),
      .src_w_to_n_data(src_data),
      .src_w_to_n_keep(src_keep),
      .src_w_to_n_last(src_last),
      .w_to_n_src_rdy (src_rdy),
      .w_to_n_dst_val (dst_val),
      .w_to_n_dst_data(dst_data),
      .w_to_n_dst_keep(dst_keep),
      .w_to_n_dst_last(dst_last),
      .dst_w_to_n_rdy (dst_rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Lowest element emitted for a line: 0 unless it ends a packet, then the
   // lowest element with any keep, or the top element if none is kept.
   function automatic int stop_el(input logic [ELS-1:0][KW-1:0] k, input logic l);
      if (!l) return 0;
      for (int i = 0; i < ELS; i++) begin
         if (k[i] != '0) return i;
      end
      return ELS - 1;
   endfunction

   // Downstream ready driver.
   initial begin
      dst_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         dst_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: model expectations vs DUT outputs every cycle.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            check("rst_src_rdy", src_rdy, 0);
            check("rst_dst_val", dst_val, 0);
            exp_q.delete();
         end else begin
            automatic bit exp_vld  = (exp_q.size() > 0);
            automatic bit exp_srdy = (exp_q.size() == 0) || (exp_q.size() == 1 && dst_rdy);
            check("dst_val", dst_val, exp_vld);
            check("src_rdy", src_rdy, exp_srdy);
            if (dst_val && exp_vld) begin
               check("beat_data", dst_data, exp_q[0].data);
               check("beat_keep", dst_keep, exp_q[0].keep);
               check("beat_last", dst_last, exp_q[0].last);
               if (dst_rdy) begin
                  log_q.push_back('{dst_data, dst_keep, dst_last});
                  log_cyc.push_back(cyc);
                  void'(exp_q.pop_front());
               end
            end
            if (src_val && src_rdy) begin
               automatic int st = stop_el(src_keep, src_last);
               for (int e = ELS - 1; e >= st; e--) begin
                  exp_q.push_back('{src_data[e], src_keep[e], src_last && (e == st)});
               end
            end
         end
      end
   end

   task automatic scramble();
      src_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      src_keep = 16'($urandom());
      src_last = 1'($urandom_range(0, 1));
   endtask

   task automatic send_line(input logic [ELS-1:0][DW-1:0] d,
                            input logic [ELS-1:0][KW-1:0] k,
                            input logic l);
      bit ok;
      ok       = 0;
      src_val  = 1'b1;
      src_data = d;
      src_keep = k;
      src_last = l;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (src_rdy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL src_accept_timeout: got no src_rdy, required acceptance");
      end
      @(posedge clk);
      #1;
      src_val = 1'b0;
      scramble();
   endtask

   task automatic drain();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !dst_val) break;
      end
      check("drain_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      logic [ELS-1:0][KW-1:0] kk;
      rst     = 1'b1;
      src_val = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // first cycle out of reset
      @(negedge clk);
      check("post_rst_src_rdy", src_rdy, 1);
      check("post_rst_dst_val", dst_val, 0);
      check("post_rst_dst_last", dst_last, 0);
      @(posedge clk);
      #1;

      // pin the model against hand-computed values
      check("pin_stop_ff30", stop_el({4'hF, 4'hF, 4'h3, 4'h0}, 1'b1), 1);
      check("pin_stop_f000", stop_el({4'hF, 4'h0, 4'h0, 4'h0}, 1'b1), 3);
      check("pin_stop_zero", stop_el(16'h0, 1'b1), 3);
      check("pin_stop_nolast", stop_el({4'h0, 4'h0, 4'hF, 4'h0}, 1'b0), 0);

      // test 1: plain line, four beats in order A,B,C,D
      base = log_q.size();
      send_line({32'hAAAA_0003, 32'hBBBB_0002, 32'hCCCC_0001, 32'hDDDD_0000}, 16'hFFFF, 1'b0);
      drain();
      check("t1_count", log_q.size() - base, 4);
      check("t1_b0", log_q[base + 0].data, 32'hAAAA_0003);
      check("t1_b1", log_q[base + 1].data, 32'hBBBB_0002);
      check("t1_b2", log_q[base + 2].data, 32'hCCCC_0001);
      check("t1_b3", log_q[base + 3].data, 32'hDDDD_0000);
      check("t1_keep", log_q[base + 3].keep, 4'hF);
      check("t1_last", log_q[base + 3].last, 0);
      check("t1_span", log_cyc[base + 3] - log_cyc[base], 3);

      // test 2: final line with trailing empty element
      base = log_q.size();
      send_line({32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000},
                {4'hF, 4'hF, 4'h3, 4'h0}, 1'b1);
      drain();
      check("t2_count", log_q.size() - base, 3);
      check("t2_keep2", log_q[base + 2].keep, 4'h3);
      check("t2_data2", log_q[base + 2].data, 32'h1000_0001);
      check("t2_last1", log_q[base + 1].last, 0);
      check("t2_last2", log_q[base + 2].last, 1);
      @(negedge clk);
      check("t2_ready_again", {src_rdy, dst_val}, 2'b10);
      @(posedge clk);
      #1;

      // test 3: single kept element, then nothing kept
      base = log_q.size();
      send_line({32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000},
                {4'hF, 4'h0, 4'h0, 4'h0}, 1'b1);
      drain();
      check("t3a_count", log_q.size() - base, 1);
      check("t3a_beat", log_q[base], {32'h2000_0003, 4'hF, 1'b1});
      base = log_q.size();
      send_line({32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000}, 16'h0, 1'b1);
      drain();
      check("t3b_count", log_q.size() - base, 1);
      check("t3b_beat", log_q[base], {32'h3000_0003, 4'h0, 1'b1});

      // test 4: back-to-back lines, no bubble
      base = log_q.size();
      send_line({32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000}, 16'hFFFF, 1'b0);
      send_line({32'h4100_0003, 32'h4100_0002, 32'h4100_0001, 32'h4100_0000}, 16'hFFFF, 1'b1);
      drain();
      check("t4_count", log_q.size() - base, 8);
      check("t4_span", log_cyc[base + 7] - log_cyc[base], 7);
      check("t4_b4", log_q[base + 4].data, 32'h4100_0003);
      check("t4_last", log_q[base + 7].last, 1);

      // test 5: three-line packet under random backpressure
      rand_rdy = 1;
      base = log_q.size();
      kk = {4'hF, 4'h3, 4'h0, 4'h0};
      send_line({$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()), 1'b0);
      send_line({$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()), 1'b0);
      send_line({$urandom(), $urandom(), $urandom(), $urandom()}, kk, 1'b1);
      drain();
      check("t5_count", log_q.size() - base, 10);
      check("t5_last", log_q[base + 9].last, 1);

      // random lines with gaps, random keep and last
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         for (int e = 0; e < ELS; e++) begin
            kk[e] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom());
         end
         send_line({$urandom(), $urandom(), $urandom(), $urandom()}, kk,
                   1'($urandom_range(0, 2) == 0));
      end
      drain();

      // test 6: reset after the second beat of a line
      rand_rdy = 0;
      @(posedge clk);
      #1;
      base = log_q.size();
      send_line({32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000}, 16'hFFFF, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_partial", log_q.size() - base, 2);
      check("t6_ready", {src_rdy, dst_val}, 2'b10);
      @(posedge clk);
      #1;
      base = log_q.size();
      send_line({32'h7000_0003, 32'h7000_0002, 32'h7000_0001, 32'h7000_0000}, 16'hFFFF, 1'b1);
      drain();
      check("t6_full", log_q.size() - base, 4);
      check("t6_first", log_q[base].data, 32'h7000_0003);
      check("t6_last", log_q[base + 3], {32'h7000_0000, 4'hF, 1'b1});

      check("final_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
